fp_mul_pipe: RTL

Parametrised 3-stage pipelined IEEE-style floating-point multiplier with a valid/ready handshake on both sides, full backpressure and a passthrough tag. It is the next-generation multiplier for the probabilistic-circuit node datapath. It covers bf16 (default), fp16 and fp32 through width parameters. It adds round-to-nearest-even, exception flags and stall support.

---
 rtl/fp_mul_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (bf16 by default) with RNE rounding,
// DAZ/FTZ, exception flags, valid/ready handshake on both sides and a passthrough tag.
module fp_mul_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_z,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               out_flags
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * SW;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Ready chain: each stage may load when empty or when its occupant leaves this cycle
    logic s1_v, s2_v;
    logic s1_rdy_c, s2_rdy_c, s3_rdy_c;

    assign s3_rdy_c = !out_valid || out_ready;
    assign s2_rdy_c = !s2_v || s3_rdy_c;
    assign s1_rdy_c = !s1_v || s2_rdy_c;
    assign in_ready = s1_rdy_c && !rst;

    // ------------------------------------------------------------------
    // S1: unpack and classify
    // ------------------------------------------------------------------
    logic              sa_c, sb_c;
    logic [EXP_W-1:0]  ea_c, eb_c;
    logic [MAN_W-1:0]  ma_c, mb_c;
    logic              a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_zero_c, b_zero_c;
    logic              sign_c;
    logic              spec_c;
    logic [W-1:0]      spec_z_c;
    logic [3:0]        spec_f_c;
    logic [EW-1:0]     ez_c;

    assign {sa_c, ea_c, ma_c} = in_a;
    assign {sb_c, eb_c, mb_c} = in_b;

    always_comb begin : s1_classify
        a_nan_c  = (&ea_c) && (|ma_c);
        b_nan_c  = (&eb_c) && (|mb_c);
        a_inf_c  = (&ea_c) && !(|ma_c);
        b_inf_c  = (&eb_c) && !(|mb_c);
        a_zero_c = !(|ea_c);
        b_zero_c = !(|eb_c);
        sign_c   = sa_c ^ sb_c;
        ez_c     = EW'(ea_c) + EW'(eb_c) - EW'(BIAS);

        spec_c   = 1'b1;
        spec_z_c = QNAN;
        spec_f_c = 4'b0000;
        if (a_nan_c || b_nan_c) begin
            spec_z_c = QNAN;
        end else if ((a_inf_c && b_zero_c) || (a_zero_c && b_inf_c)) begin
            spec_z_c = QNAN;
            spec_f_c = 4'b1000;
        end else if (a_inf_c || b_inf_c) begin
            spec_z_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero_c || b_zero_c) begin
            spec_z_c = {sign_c, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            spec_c = 1'b0;
        end
    end

    logic              s1_sign;
    logic              s1_spec;
    logic [W-1:0]      s1_spec_z;
    logic [3:0]        s1_spec_f;
    logic [SW-1:0]     s1_ma, s1_mb;
    logic [EW-1:0]     s1_ez;
    logic [TAG_W-1:0]  s1_tag;

    always_ff @(posedge clk) begin : s1_reg
        if (rst) begin
            s1_v      <= 1'b0;
            s1_sign   <= 1'b0;
            s1_spec   <= 1'b0;
            s1_spec_z <= '0;
            s1_spec_f <= '0;
            s1_ma     <= '0;
            s1_mb     <= '0;
            s1_ez     <= '0;
            s1_tag    <= '0;
        end else if (s1_rdy_c) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_sign   <= sign_c;
                s1_spec   <= spec_c;
                s1_spec_z <= spec_z_c;
                s1_spec_f <= spec_f_c;
                s1_ma     <= {1'b1, ma_c};
                s1_mb     <= {1'b1, mb_c};
                s1_ez     <= ez_c;
                s1_tag    <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: significand multiply
    // ------------------------------------------------------------------
    logic              s2_sign;
    logic              s2_spec;
    logic [W-1:0]      s2_spec_z;
    logic [3:0]        s2_spec_f;
    logic [PW-1:0]     s2_prod;
    logic [EW-1:0]     s2_ez;
    logic [TAG_W-1:0]  s2_tag;

    always_ff @(posedge clk) begin : s2_reg
        if (rst) begin
            s2_v      <= 1'b0;
            s2_sign   <= 1'b0;
            s2_spec   <= 1'b0;
            s2_spec_z <= '0;
            s2_spec_f <= '0;
            s2_prod   <= '0;
            s2_ez     <= '0;
            s2_tag    <= '0;
        end else if (s2_rdy_c) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_sign   <= s1_sign;
                s2_spec   <= s1_spec;
                s2_spec_z <= s1_spec_z;
                s2_spec_f <= s1_spec_f;
                s2_prod   <= PW'(s1_ma) * PW'(s1_mb);
                s2_ez     <= s1_ez;
                s2_tag    <= s1_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise, round to nearest even, range check, pack
    // ------------------------------------------------------------------
    logic [PW-2:0]     pn_c;
    logic [MAN_W-1:0]  man_c, man_r_c;
    logic              guard_c, sticky_c, rnd_c, carry_c;
    logic [EW-1:0]     ez_r_c;
    logic              ovf_c, unf_c;
    logic [W-1:0]      z_c;
    logic [3:0]        f_c;

    always_comb begin : s3_round_pack
        pn_c     = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
        man_c    = pn_c[PW-2 -: MAN_W];
        guard_c  = pn_c[PW-2-MAN_W];
        sticky_c = |pn_c[PW-3-MAN_W:0];
        rnd_c    = guard_c && (sticky_c || man_c[0]);
        {carry_c, man_r_c} = {1'b0, man_c} + SW'(rnd_c);
        ez_r_c   = s2_ez + EW'(s2_prod[PW-1]) + EW'(carry_c);
        // ez_r_c is two's complement; the MSB marks a negative exponent
        ovf_c    = !ez_r_c[EW-1] && (ez_r_c >= EXP_MAX);
        unf_c    = ez_r_c[EW-1] || (ez_r_c == '0);

        z_c = {s2_sign, ez_r_c[EXP_W-1:0], man_r_c};
        f_c = {3'b000, guard_c || sticky_c};
        if (s2_spec) begin
            z_c = s2_spec_z;
            f_c = s2_spec_f;
        end else if (ovf_c) begin
            z_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            f_c = 4'b0101;
        end else if (unf_c) begin
            z_c = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            f_c = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin : s3_reg
        if (rst) begin
            out_valid <= 1'b0;
            out_z     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (s3_rdy_c) begin
            out_valid <= s2_v;
            if (s2_v) begin
                out_z     <= z_c;
                out_tag   <= s2_tag;
                out_flags <= f_c;
            end
        end
    end

endmodule
